sw_debounce: RTL and testbench

- Conditions raw NVBoard switch/button inputs before they reach the top-level XOR datapath.
- Each channel is passed through a 2-flop synchronizer, then a per-channel stable-count debouncer.
- Outputs are a clean level plus single-cycle rise/fall pulses for each channel.
- level_o[0] drives the XOR input a; level_o[1] drives b.

---
 rtl/sw_debounce.sv | 90 +++++++++
 tb/tb_sw_debounce.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - per-channel 2-flop synchronizer plus stable-count debouncer with edge pulses
module sw_debounce #(
  parameter int N             = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] raw_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] rise_o,
  output logic [N-1:0] fall_o,
  output logic         chg_o
);

  // Count value on which the pending level is accepted.
  localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CYCLES - 1);

  // Refuse to build when the counter cannot reach the terminal value.
  generate
    if (STABLE_CYCLES < 1 || (CNT_W < 31 && STABLE_CYCLES > (1 << CNT_W))) begin : g_bad_param
      $error("sw_debounce: STABLE_CYCLES must be >= 1 and fit in CNT_W bits");
    end
  endgenerate

  logic [N-1:0] r_s1;
  logic [N-1:0] r_s2;
  logic [N-1:0] r_level;
  logic [N-1:0] r_rise;
  logic [N-1:0] r_fall;
  logic         r_chg;
  logic [CNT_W-1:0] r_cnt [N];

  logic [N-1:0] w_level_nxt;
  logic [N-1:0] w_rise_nxt;
  logic [N-1:0] w_fall_nxt;
  logic         w_chg_nxt;
  logic [CNT_W-1:0] w_cnt_nxt [N];

  // Next-state per channel: state is implied by s2 != level (COUNT) or s2 == level (IDLE).
  always_comb begin
    w_level_nxt = r_level;
    w_rise_nxt  = '0;
    w_fall_nxt  = '0;
    for (int i = 0; i < N; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_s2[i] != r_level[i]) begin
        if (r_cnt[i] == TERM) begin
          w_level_nxt[i] = r_s2[i];
          w_rise_nxt[i]  = r_s2[i];
          w_fall_nxt[i]  = ~r_s2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
    w_chg_nxt = |(w_rise_nxt | w_fall_nxt);
  end

  // Synchronizer, counters, level and registered pulses; a reset discards any partial count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_level <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_chg   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1    <= raw_i;
      r_s2    <= r_s1;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_chg   <= w_chg_nxt;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign level_o = r_level;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;
  assign chg_o   = r_chg;

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - directed self-checking bench for sw_debounce
module tb_sw_debounce;

  logic       clk;
  logic       rst;
  logic [1:0] raw;
  logic [1:0] level;
  logic [1:0] rise;
  logic [1:0] fall;
  logic       chg;
  logic [1:0] raw1;
  logic [1:0] level1;
  logic [1:0] rise1;
  logic [1:0] fall1;
  logic       chg1;

  int checks;
  int errors;

  sw_debounce #(.N(2), .STABLE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .raw_i(raw),
    .level_o(level), .rise_o(rise), .fall_o(fall), .chg_o(chg)
  );

  sw_debounce #(.N(2), .STABLE_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .raw_i(raw1),
    .level_o(level1), .rise_o(rise1), .fall_o(fall1), .chg_o(chg1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    raw  = 2'b11;
    raw1 = 2'b11;
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++;
      if ({level, rise, fall, chg} !== 7'h00) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got lvl=%b rise=%b fall=%b chg=%b want all 0", c, level, rise, fall, chg);
      end
      checks++;
      if ({level1, rise1, fall1, chg1} !== 7'h00) begin
        errors++;
        $display("FAIL reset_hold_s1 cyc=%0d got lvl=%b rise=%b fall=%b chg=%b want all 0", c, level1, rise1, fall1, chg1);
      end
    end
    raw  = 2'b00;
    raw1 = 2'b00;
    tick();
  endtask

  task automatic test_rise();
    logic [1:0] el, er;
    logic       ec;
    rst = 1'b0;
    raw = 2'b01;
    for (int e = 1; e <= 8; e++) begin
      tick();
      el = (e >= 6) ? 2'b01 : 2'b00;
      er = (e == 6) ? 2'b01 : 2'b00;
      ec = (e == 6);
      checks++;
      if ({level, rise, fall, chg} !== {el, er, 2'b00, ec}) begin
        errors++;
        $display("FAIL rise edge=%0d got lvl=%b rise=%b fall=%b chg=%b want lvl=%b rise=%b fall=00 chg=%b",
                 e, level, rise, fall, chg, el, er, ec);
      end
    end
  endtask

  task automatic test_fall();
    logic [1:0] el, ef;
    logic       ec;
    raw = 2'b11;
    repeat (8) tick();
    checks++;
    if (level !== 2'b11) begin
      errors++;
      $display("FAIL fall_setup got lvl=%b want 11", level);
    end
    raw = 2'b00;
    for (int e = 1; e <= 8; e++) begin
      tick();
      el = (e >= 6) ? 2'b00 : 2'b11;
      ef = (e == 6) ? 2'b11 : 2'b00;
      ec = (e == 6);
      checks++;
      if ({level, rise, fall, chg} !== {el, 2'b00, ef, ec}) begin
        errors++;
        $display("FAIL fall edge=%0d got lvl=%b rise=%b fall=%b chg=%b want lvl=%b rise=00 fall=%b chg=%b",
                 e, level, rise, fall, chg, el, ef, ec);
      end
    end
  endtask

  task automatic test_bounce();
    logic pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0] el, er;
    int pulses;
    pulses = 0;
    for (int e = 1; e <= 12; e++) begin
      raw = {1'b0, (e <= 8) ? pat[e-1] : 1'b1};
      tick();
      el = (e >= 10) ? 2'b01 : 2'b00;
      er = (e == 10) ? 2'b01 : 2'b00;
      if (rise[0]) pulses++;
      checks++;
      if ({level, rise, fall} !== {el, er, 2'b00}) begin
        errors++;
        $display("FAIL bounce edge=%0d got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=00",
                 e, level, rise, fall, el, er);
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL bounce_pulse_count got %0d want 1", pulses);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] el, er;
    rst = 1'b1;
    raw = 2'b00;
    tick();
    rst = 1'b0;
    raw = 2'b01;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({level, rise, fall, chg} !== 7'h00) begin
      errors++;
      $display("FAIL reset_mid got lvl=%b rise=%b fall=%b chg=%b want all 0", level, rise, fall, chg);
    end
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      el = (e >= 6) ? 2'b01 : 2'b00;
      er = (e == 6) ? 2'b01 : 2'b00;
      checks++;
      if ({level, rise, fall} !== {el, er, 2'b00}) begin
        errors++;
        $display("FAIL reset_release edge=%0d got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=00",
                 e, level, rise, fall, el, er);
      end
    end
  endtask

  task automatic test_single_cycle();
    logic pat [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic el, ep, er, ef;
    for (int e = 1; e <= 14; e++) begin
      raw1 = {1'b0, (e <= 12) ? pat[e-1] : 1'b0};
      tick();
      el = (e >= 3 && e - 2 <= 12) ? pat[e-3] : 1'b0;
      ep = (e >= 4 && e - 3 <= 12) ? pat[e-4] : 1'b0;
      er = el & ~ep;
      ef = ~el & ep;
      checks++;
      if ({level1, rise1, fall1, chg1} !== {1'b0, el, 1'b0, er, 1'b0, ef, er | ef}) begin
        errors++;
        $display("FAIL single_cycle edge=%0d got lvl=%b rise=%b fall=%b chg=%b want lvl=0%b rise=0%b fall=0%b chg=%b",
                 e, level1, rise1, fall1, chg1, el, er, ef, er | ef);
      end
    end
  endtask

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    raw    = 2'b00;
    raw1   = 2'b00;
    checks = 0;
    errors = 0;
    test_reset();
    test_rise();
    test_fall();
    test_bounce();
    test_reset_mid();
    test_single_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
